// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage access unit: size codes, FSM states,
// latched operand payload and the size/alignment helpers.
package mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RD_W   = 4;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  // Operands captured from EXE/MEM when a memory instruction is accepted
  typedef struct packed {
    logic              load;
    logic              sgn;
    size_e             size;
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;
    logic              rf_en;
    logic              fault;
  } mem_op_t;

  // Number of bytes moved for a size code (0 for the reserved code)
  function automatic logic [CNT_W-1:0] byte_count(input size_e size);
    logic [CNT_W-1:0] n;
    case (size)
      SZ_BYTE: n = CNT_W'(1);
      SZ_HALF: n = CNT_W'(2);
      SZ_WORD: n = CNT_W'(4);
      default: n = '0;
    endcase
    return n;
  endfunction

  // Natural alignment check; the reserved size is never legal
  function automatic logic is_aligned(input size_e size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Left-justify right-justified store data so the first (most significant) byte sits on top
  function automatic logic [DATA_W-1:0] store_msb_first(input size_e size,
                                                        input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] r;
    case (size)
      SZ_BYTE: r = {data[BYTE_W-1:0], {(DATA_W-BYTE_W){1'b0}}};
      SZ_HALF: r = {data[2*BYTE_W-1:0], {(DATA_W-2*BYTE_W){1'b0}}};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Turns the big-endian load accumulator into a 32-bit register value,
// sign- or zero-extending byte and halfword loads.
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] acc,
  input  size_e             size,
  input  logic              is_signed,
  output logic [DATA_W-1:0] data_c
);

  // Select the loaded width and extend it
  always_comb begin
    data_c = acc;
    case (size)
      SZ_BYTE: data_c = {{(DATA_W-BYTE_W){is_signed & acc[BYTE_W-1]}}, acc[BYTE_W-1:0]};
      SZ_HALF: data_c = {{(DATA_W-2*BYTE_W){is_signed & acc[2*BYTE_W-1]}}, acc[2*BYTE_W-1:0]};
      default: data_c = acc;
    endcase
  end

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage access unit: consumes the EXE/MEM register, performs loads and
// stores one byte per handshake (big-endian) on a byte-wide RAM, stalls the
// pipeline while busy and presents a registered MEM/WB payload.
module mem_stage_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_en,
  input  logic              load_inst,
  input  logic              mem_signed,
  input  logic [1:0]        data_size,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              rf_en_in,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_rf_en,
  output logic              fault,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_wdata,
  input  logic [BYTE_W-1:0] ram_rdata,
  input  logic              ram_ack
);

  localparam int unsigned WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  state_e            state;
  mem_op_t           op;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] st_shift;
  logic [CNT_W-1:0]  remaining;
  logic [WAIT_W-1:0] wait_cnt;

  size_e             req_size;
  logic              req_ok;
  logic [DATA_W-1:0] st_first;
  logic [DATA_W-1:0] load_val_c;

  assign req_size = size_e'(data_size);
  assign req_ok   = is_aligned(req_size, alu_out[1:0]);
  assign st_first = store_msb_first(req_size, store_data);

  // Hold the front of the pipeline while a memory instruction is being accepted or is in flight
  assign stall = ~reset & (((state == ST_IDLE) & mem_en) | (state == ST_ACCESS));

  mem_load_extend u_load_extend (
    .acc       (acc),
    .size      (op.size),
    .is_signed (op.sgn),
    .data_c    (load_val_c)
  );

  // Access FSM, byte sequencing, ack timeout and MEM/WB output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op        <= '0;
      acc       <= '0;
      st_shift  <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      wb_rf_en  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!mem_en) begin
            wb_valid <= 1'b1;
            wb_data  <= alu_out;
            wb_rd    <= rd_in;
            wb_rf_en <= rf_en_in;
          end else begin
            op <= '{load:  load_inst,
                    sgn:   mem_signed,
                    size:  req_size,
                    alu:   alu_out,
                    rd:    rd_in,
                    rf_en: rf_en_in,
                    fault: ~req_ok};
            acc      <= '0;
            wait_cnt <= '0;
            if (req_ok) begin
              state     <= ST_ACCESS;
              ram_req   <= 1'b1;
              ram_we    <= ~load_inst;
              ram_addr  <= ADDR_W'(alu_out);
              ram_wdata <= st_first[DATA_W-1 -: BYTE_W];
              st_shift  <= st_first << BYTE_W;
              remaining <= byte_count(req_size);
            end else begin
              state <= ST_DONE;
            end
          end
        end

        ST_ACCESS: begin
          if (ram_ack) begin
            acc      <= {acc[DATA_W-BYTE_W-1:0], ram_rdata};
            wait_cnt <= '0;
            if (remaining == CNT_W'(1)) begin
              ram_req <= 1'b0;
              ram_we  <= 1'b0;
              state   <= ST_DONE;
            end else begin
              remaining <= remaining - CNT_W'(1);
              ram_addr  <= ram_addr + ADDR_W'(1);
              ram_wdata <= st_shift[DATA_W-1 -: BYTE_W];
              st_shift  <= st_shift << BYTE_W;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            ram_req  <= 1'b0;
            ram_we   <= 1'b0;
            op.fault <= 1'b1;
            state    <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        ST_DONE: begin
          wb_valid <= 1'b1;
          wb_data  <= (op.load & ~op.fault) ? load_val_c : op.alu;
          wb_rd    <= op.rd;
          wb_rf_en <= op.rf_en & ~op.fault;
          fault    <= op.fault;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Bench for mem_stage_access_unit: constant vector table, an abort-by-reset
// sequence and randomized instructions checked against a byte-array memory model.
module tb_mem_stage_access_unit;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned ACK_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_en, load_inst, mem_signed;
  logic [1:0]  data_size;
  logic [31:0] alu_out, store_data;
  logic [3:0]  rd_in;
  logic        rf_en_in;
  logic        stall, wb_valid;
  logic [31:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_rf_en, fault;
  logic        ram_req, ram_we;
  logic [7:0]  ram_addr, ram_wdata, ram_rdata;
  logic        ram_ack;

  always #5 clk = ~clk;

  mem_stage_access_unit #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .mem_en(mem_en), .load_inst(load_inst),
    .mem_signed(mem_signed), .data_size(data_size), .alu_out(alu_out),
    .store_data(store_data), .rd_in(rd_in), .rf_en_in(rf_en_in),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_rf_en(wb_rf_en), .fault(fault), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_ack(ram_ack)
  );

  typedef struct {
    bit          mem_en;
    bit          load;
    bit          sgn;
    logic [1:0]  size;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [3:0]  rd;
    bit          rf_en;
    int unsigned delay;
  } instr_t;

  typedef struct {
    bit          fault;
    bit          chk_data;
    logic [31:0] data;
    bit          rf_en;
    int unsigned stalls;
    int unsigned reqs;
  } exp_t;

  typedef struct {
    instr_t ins;
    exp_t   ex;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  logic [7:0]  ram_mem [256];
  logic [7:0]  exp_mem [256];
  logic [15:0] wr_log[$];
  logic [15:0] exp_wr[$];
  int unsigned ack_delay = 0;
  int unsigned wcnt = 0;
  int unsigned req_cycles = 0;
  bit          stray_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM environment: acks each byte after ack_delay wait cycles, commits writes, may throw stray acks
  initial begin
    ram_ack   = 1'b0;
    ram_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (ram_req === 1'b1) begin
        req_cycles++;
        if (ram_ack) begin
          if (ram_we) begin
            ram_mem[ram_addr] = ram_wdata;
            wr_log.push_back({ram_addr, ram_wdata});
          end
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      #1;
      if (ram_req === 1'b1) begin
        ram_ack   = (wcnt >= ack_delay);
        ram_rdata = ram_ack ? ram_mem[ram_addr] : 8'($urandom);
      end else begin
        ram_ack   = stray_en && ($urandom_range(0, 3) == 0);
        ram_rdata = 8'($urandom);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic instr_t mk(bit m, bit ld, bit sg, logic [1:0] sz, logic [31:0] a,
                                logic [31:0] sd, logic [3:0] rd, bit rf, int unsigned d);
    instr_t r;
    r.mem_en = m; r.load = ld; r.sgn = sg; r.size = sz; r.alu = a;
    r.sdata = sd; r.rd = rd; r.rf_en = rf; r.delay = d;
    return r;
  endfunction

  function automatic exp_t mkx(bit f, bit cd, logic [31:0] data, bit rf,
                               int unsigned st, int unsigned rq);
    exp_t r;
    r.fault = f; r.chk_data = cd; r.data = data; r.rf_en = rf; r.stalls = st; r.reqs = rq;
    return r;
  endfunction

  // Reference: what the instruction should do to memory and what WB should see
  task automatic model_instr(input instr_t ins, output exp_t e);
    int unsigned nb;
    logic [31:0] v;
    logic [7:0]  a, b;
    exp_wr.delete();
    e = mkx(0, 1, ins.alu, ins.rf_en, 0, 0);
    if (ins.mem_en) begin
      case (ins.size)
        2'b00:   nb = 1;
        2'b01:   nb = 2;
        2'b10:   nb = 4;
        default: nb = 0;
      endcase
      if (nb == 0 || (ins.alu % nb) != 0) begin
        e = mkx(1, 0, 0, 0, 1, 0);
      end else if (ins.delay >= ACK_TIMEOUT) begin
        e = mkx(1, 0, 0, 0, 1 + ACK_TIMEOUT, ACK_TIMEOUT);
      end else begin
        e.stalls = 1 + nb * (ins.delay + 1);
        e.reqs   = nb * (ins.delay + 1);
        a = ins.alu[7:0];
        if (ins.load) begin
          v = 0;
          for (int k = 0; k < nb; k++) v = v * 256 + 32'(exp_mem[8'(a + 8'(k))]);
          if (ins.sgn && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
          e.data = v;
        end else begin
          for (int k = 0; k < nb; k++) begin
            b = 8'(ins.sdata >> (8 * (nb - 1 - k)));
            exp_mem[8'(a + 8'(k))] = b;
            exp_wr.push_back({8'(a + 8'(k)), b});
          end
        end
      end
    end
  endtask

  task automatic drive(input instr_t ins);
    mem_en = ins.mem_en; load_inst = ins.load; mem_signed = ins.sgn;
    data_size = ins.size; alu_out = ins.alu; store_data = ins.sdata;
    rd_in = ins.rd; rf_en_in = ins.rf_en; ack_delay = ins.delay;
  endtask

  // Present one instruction as the EXE/MEM register would, hold it while stalled, check its WB pulse
  task automatic run_instr(input instr_t ins, input exp_t e, input string tag);
    int unsigned stalls, late_valid;
    stalls = 0;
    late_valid = 0;
    drive(ins);
    req_cycles = 0;
    wr_log.delete();
    #1;
    while (stall === 1'b1 && stalls < 64) begin
      stalls++;
      @(posedge clk); #2;
      if (wb_valid !== 1'b0) late_valid++;
    end
    @(posedge clk); #1;
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
    if (e.chk_data) check({tag, ".wb_data"}, wb_data, e.data);
    check({tag, ".wb_rd"}, 32'(wb_rd), 32'(ins.rd));
    check({tag, ".wb_rf_en"}, 32'(wb_rf_en), 32'(e.rf_en));
    check({tag, ".fault"}, 32'(fault), 32'(e.fault));
    check({tag, ".stall_cycles"}, 32'(stalls), 32'(e.stalls));
    check({tag, ".req_cycles"}, 32'(req_cycles), 32'(e.reqs));
    check({tag, ".early_valid"}, 32'(late_valid), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    instr_t ins;
    exp_t   e;
    int unsigned r;

    for (int i = 0; i < 256; i++) ram_mem[i] = 8'($urandom);
    ram_mem[8'h21] = 8'h80;
    ram_mem[8'h40] = 8'hA5;
    ram_mem[8'h41] = 8'h5A;

    //               mem ld sg size   alu            sdata          rd  rf  delay
    vecs.push_back('{mk(0, 0, 0, 2'b00, 32'h1234_5678, 32'h0,         3, 1, 0),
                     mkx(0, 1, 32'h1234_5678, 1, 0, 0)});
    vecs.push_back('{mk(1, 0, 0, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0),
                     mkx(0, 1, 32'h0000_0010, 0, 5, 4)});
    vecs.push_back('{mk(1, 1, 1, 2'b00, 32'h0000_0021, 32'h0,         5, 1, 3),
                     mkx(0, 1, 32'hFFFF_FF80, 1, 5, 4)});
    vecs.push_back('{mk(1, 1, 0, 2'b00, 32'h0000_0021, 32'h0,         6, 1, 3),
                     mkx(0, 1, 32'h0000_0080, 1, 5, 4)});
    vecs.push_back('{mk(1, 1, 0, 2'b01, 32'h0000_0003, 32'h0,         7, 1, 0),
                     mkx(1, 0, 32'h0, 0, 1, 0)});
    vecs.push_back('{mk(1, 1, 0, 2'b10, 32'h0000_0030, 32'h0,         8, 1, 15),
                     mkx(1, 0, 32'h0, 0, 16, 15)});
    vecs.push_back('{mk(1, 0, 0, 2'b10, 32'h0000_00FC, 32'hCAFE_F00D, 0, 0, 1),
                     mkx(0, 1, 32'h0000_00FC, 0, 9, 8)});
    vecs.push_back('{mk(1, 0, 0, 2'b10, 32'h0000_00FE, 32'h1111_2222, 0, 0, 0),
                     mkx(1, 0, 32'h0, 0, 1, 0)});
    vecs.push_back('{mk(1, 1, 0, 2'b11, 32'h0000_0020, 32'h0,         1, 1, 0),
                     mkx(1, 0, 32'h0, 0, 1, 0)});
    vecs.push_back('{mk(1, 1, 1, 2'b01, 32'h0000_0040, 32'h0,         9, 1, 0),
                     mkx(0, 1, 32'hFFFF_A55A, 1, 3, 2)});
    vecs.push_back('{mk(1, 1, 0, 2'b01, 32'h0000_0040, 32'h0,        10, 1, 2),
                     mkx(0, 1, 32'h0000_A55A, 1, 7, 6)});
    vecs.push_back('{mk(1, 1, 0, 2'b00, 32'h0000_0021, 32'h0,        11, 1, 14),
                     mkx(0, 1, 32'h0000_0080, 1, 16, 15)});
    vecs.push_back('{mk(1, 1, 0, 2'b00, 32'h0000_0021, 32'h0,        12, 1, 15),
                     mkx(1, 0, 32'h0, 0, 16, 15)});
    vecs.push_back('{mk(1, 1, 1, 2'b10, 32'hABCD_0010, 32'h0,         2, 1, 0),
                     mkx(0, 1, 32'hDEAD_BEEF, 1, 5, 4)});
    vecs.push_back('{mk(1, 0, 0, 2'b01, 32'h0000_0024, 32'h1234_ABCD, 0, 0, 0),
                     mkx(0, 1, 32'h0000_0024, 0, 3, 2)});
    vecs.push_back('{mk(0, 1, 1, 2'b10, 32'hFFFF_FFFF, 32'h0,        15, 0, 0),
                     mkx(0, 1, 32'hFFFF_FFFF, 0, 0, 0)});

    // Reset state, with a memory instruction already waiting at the input
    reset = 1'b1;
    drive(mk(1, 1, 0, 2'b10, 32'h0, 32'h0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #2;
    check("reset.ram_req", 32'(ram_req), 32'd0);
    check("reset.ram_we", 32'(ram_we), 32'd0);
    check("reset.stall", 32'(stall), 32'd0);
    check("reset.wb_valid", 32'(wb_valid), 32'd0);
    check("reset.wb_data", wb_data, 32'd0);
    check("reset.wb_rd", 32'(wb_rd), 32'd0);
    check("reset.wb_rf_en", 32'(wb_rf_en), 32'd0);
    check("reset.fault", 32'(fault), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) run_instr(vecs[i].ins, vecs[i].ex, $sformatf("vec%0d", i));

    check("mem.0x10", 32'(ram_mem[8'h10]), 32'hDE);
    check("mem.0x11", 32'(ram_mem[8'h11]), 32'hAD);
    check("mem.0x12", 32'(ram_mem[8'h12]), 32'hBE);
    check("mem.0x13", 32'(ram_mem[8'h13]), 32'hEF);
    check("mem.0xFC", 32'(ram_mem[8'hFC]), 32'hCA);
    check("mem.0xFD", 32'(ram_mem[8'hFD]), 32'hFE);
    check("mem.0xFE", 32'(ram_mem[8'hFE]), 32'hF0);
    check("mem.0xFF", 32'(ram_mem[8'hFF]), 32'h0D);
    check("mem.0x24", 32'(ram_mem[8'h24]), 32'hAB);
    check("mem.0x25", 32'(ram_mem[8'h25]), 32'hCD);

    for (int i = 0; i < 256; i++) exp_mem[i] = ram_mem[i];

    // Word load aborted by reset after its second byte, then a clean retry
    drive(mk(1, 1, 0, 2'b10, 32'h0000_0050, 32'h0, 4, 1, 0));
    repeat (3) begin @(posedge clk); #1; end
    check("abort.req_before", 32'(ram_req), 32'd1);
    check("abort.addr_before", 32'(ram_addr), 32'h52);
    reset = 1'b1;
    @(posedge clk); #2;
    check("abort.ram_req", 32'(ram_req), 32'd0);
    check("abort.stall", 32'(stall), 32'd0);
    check("abort.wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_en = 1'b0;
    check("abort.wb_valid2", 32'(wb_valid), 32'd0);
    check("abort.ram_req2", 32'(ram_req), 32'd0);
    ins = mk(0, 0, 0, 2'b00, 32'h0000_0777, 32'h0, 1, 1, 0);
    model_instr(ins, e);
    run_instr(ins, e, "abort.bubble");
    ins = mk(1, 1, 0, 2'b10, 32'h0000_0050, 32'h0, 4, 1, 0);
    model_instr(ins, e);
    run_instr(ins, e, "abort.retry");

    // Randomized instruction stream against the memory model
    stray_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ins.mem_en = ($urandom_range(0, 3) != 0);
      ins.load   = 1'($urandom_range(0, 1));
      ins.sgn    = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      ins.size   = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      ins.alu    = $urandom;
      if ($urandom_range(0, 3) != 0) ins.alu[1:0] = 2'b00;
      if ($urandom_range(0, 5) == 0) ins.alu[7:2] = 6'h3F;
      ins.sdata  = $urandom;
      ins.rd     = 4'($urandom);
      ins.rf_en  = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 19);
      ins.delay  = (r == 0) ? ACK_TIMEOUT : (r == 1) ? ACK_TIMEOUT - 1 : $urandom_range(0, 3);
      model_instr(ins, e);
      run_instr(ins, e, $sformatf("rnd%0d", i));
      check($sformatf("rnd%0d.n_writes", i), 32'(wr_log.size()), 32'(exp_wr.size()));
      if (wr_log.size() == exp_wr.size())
        foreach (exp_wr[k]) check($sformatf("rnd%0d.write%0d", i, k), 32'(wr_log[k]), 32'(exp_wr[k]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
